// File: rtl/ops_sweep_misr.sv
// Exhaustive a/b/c operand sequencer feeding a combinational operator block,
// compacting each returned result into a 32-bit MISR signature.
module ops_sweep_misr #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned RW     = 32,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  input  logic [RW-1:0]        res,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          sig,
  output logic [3*WIDTH-1:0]   idx
);

  localparam int unsigned IW = 3 * WIDTH;
  localparam int unsigned CW = 4;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx_d;
  logic [31:0]   sig_d;
  logic          done_d;
  logic          busy_d;
  logic [31:0]   sig_step;

  // One MISR step: shift with CRC-32 feedback, fold in the zero-extended result
  assign sig_step = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ 32'(res);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic; abort wins in WAIT/CAPT, start only accepted when idle
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_d = S_WAIT;
      S_WAIT: begin
        if (abort)                  state_d = S_IDLE;
        else if (cnt == CW'(1))     state_d = S_CAPT;
      end
      S_CAPT: begin
        if (abort)                  state_d = S_IDLE;
        else if (idx == IDX_LAST)   state_d = S_DONE;
        else                        state_d = S_WAIT;
      end
      default:                      state_d = S_IDLE;
    endcase
  end

  // Datapath next values; everything holds unless the current state moves it
  always_comb begin
    idx_d  = idx;
    sig_d  = sig;
    done_d = done;
    cnt_d  = cnt;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d  = '0;
          sig_d  = 32'h0;
          done_d = 1'b0;
          cnt_d  = CW'(SETTLE);
        end
      end
      S_WAIT: begin
        if (!abort && cnt != CW'(1)) cnt_d = cnt - CW'(1);
      end
      S_CAPT: begin
        if (!abort) begin
          sig_d = sig_step;
          if (idx == IDX_LAST) begin
            done_d = 1'b1;
          end else begin
            idx_d = idx + IW'(1);
            cnt_d = CW'(SETTLE);
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_WAIT) || (state_d == S_CAPT);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      sig  <= 32'h0;
      done <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
    end else begin
      idx  <= idx_d;
      sig  <= sig_d;
      done <= done_d;
      busy <= busy_d;
      cnt  <= cnt_d;
    end
  end

  // Operands are fixed slices of the registered vector index
  assign a = idx[WIDTH-1:0];
  assign b = idx[2*WIDTH-1:WIDTH];
  assign c = idx[3*WIDTH-1:2*WIDTH];

endmodule
